// File: rtl/ram_pkg.sv
// Shared types and constants for the single-port RAM with its built-in clear sweep.
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int RD_OLD = 0;
  localparam int RD_NEW = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks cnt from 0 to DEPTH-1 and writes the clear value at each address.
// It starts on reset release (RESET_CLEAR=1) or on clear_req, and ignores clear_req during a sweep.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int RESET_CLEAR = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  input  logic              done,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output state_t            state_dbg
);

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= (RESET_CLEAR != 0) ? CLEAR : IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (state == CLEAR) begin
        cnt <= done ? '0 : cnt + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (clear_req) next_state = CLEAR;
      CLEAR:   if (done)      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign busy      = (state == CLEAR);
  assign clr_we    = (state == CLEAR);
  assign clr_addr  = cnt;
  assign state_dbg = state;

endmodule

// File: rtl/ram_sp_clr.sv
// Single-port synchronous RAM with registered read data, rd_valid/err pulses and a clear sweep.
// Accesses are rejected while the sweep runs or when the address is beyond DEPTH.
module ram_sp_clr
  import ram_pkg::*;
#(
  parameter int               DATA_W      = 8,
  parameter int               ADDR_W      = 5,
  parameter int               DEPTH       = 2 ** ADDR_W,
  parameter int               RD_MODE     = RD_OLD,
  parameter int               RESET_CLEAR = 1,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              clear_req,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              done;
  state_t            seq_state;
  logic              idle;
  logic              in_range;
  logic              access;

  assign done     = (clr_addr == LAST);
  assign idle     = (seq_state == IDLE);
  assign in_range = ({1'b0, address} < DEPTH_L);
  assign access   = read_enb | write_enb;

  ram_clear_seq #(
    .ADDR_W      (ADDR_W),
    .RESET_CLEAR (RESET_CLEAR)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .done      (done),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .state_dbg (seq_state)
  );

  // The array has no reset; the sweep owns the write port whenever it is running.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLEAR_VAL;
    end else if (idle && write_enb && in_range) begin
      mem[address] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      err      <= access && (!idle || !in_range);
      if (idle && read_enb) begin
        rd_valid <= 1'b1;
        if (!in_range) begin
          data_out <= '0;
        end else if (RD_MODE == RD_NEW && write_enb) begin
          data_out <= data_in;
        end else begin
          data_out <= mem[address];
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_sp_clr.sv
// Directed bench: dut a uses the default build (old-data read-during-write, clear on reset);
// dut b uses RD_MODE=1, DEPTH=24, no reset clear and a non-zero clear value.
module tb_ram_sp_clr;

  logic       clk;
  logic       reset;

  logic [4:0] a_address;
  logic [7:0] a_data_in;
  logic       a_write_enb, a_read_enb, a_clear_req;
  logic [7:0] a_data_out;
  logic       a_rd_valid, a_busy, a_err;

  logic [4:0] b_address;
  logic [7:0] b_data_in;
  logic       b_write_enb, b_read_enb, b_clear_req;
  logic [7:0] b_data_out;
  logic       b_rd_valid, b_busy, b_err;

  int total;
  int bad;

  ram_sp_clr dut_a (
    .clk       (clk),
    .reset     (reset),
    .address   (a_address),
    .data_in   (a_data_in),
    .write_enb (a_write_enb),
    .read_enb  (a_read_enb),
    .clear_req (a_clear_req),
    .data_out  (a_data_out),
    .rd_valid  (a_rd_valid),
    .busy      (a_busy),
    .err       (a_err)
  );

  ram_sp_clr #(
    .DATA_W      (8),
    .ADDR_W      (5),
    .DEPTH       (24),
    .RD_MODE     (1),
    .RESET_CLEAR (0),
    .CLEAR_VAL   (8'hA5)
  ) dut_b (
    .clk       (clk),
    .reset     (reset),
    .address   (b_address),
    .data_in   (b_data_in),
    .write_enb (b_write_enb),
    .read_enb  (b_read_enb),
    .clear_req (b_clear_req),
    .data_out  (b_data_out),
    .rd_valid  (b_rd_valid),
    .busy      (b_busy),
    .err       (b_err)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic we, input logic re, input logic [4:0] addr, input logic [7:0] din);
    @(negedge clk);
    a_write_enb = we;
    a_read_enb  = re;
    a_address   = addr;
    a_data_in   = din;
  endtask

  task automatic b_drive(input logic we, input logic re, input logic [4:0] addr, input logic [7:0] din);
    @(negedge clk);
    b_write_enb = we;
    b_read_enb  = re;
    b_address   = addr;
    b_data_in   = din;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    a_address = '0; a_data_in = '0; a_write_enb = 0; a_read_enb = 0; a_clear_req = 0;
    b_address = '0; b_data_in = '0; b_write_enb = 0; b_read_enb = 0; b_clear_req = 0;
    repeat (3) tick();
    total++; if (a_data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h exp=00", a_data_out); end
    total++; if (a_rd_valid !== 1'b0)  begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", a_rd_valid); end
    total++; if (a_err !== 1'b0)       begin bad++; $display("FAIL reset_err got=%b exp=0", a_err); end
    total++; if (a_busy !== 1'b1)      begin bad++; $display("FAIL reset_busy_a got=%b exp=1", a_busy); end
    total++; if (b_busy !== 1'b0)      begin bad++; $display("FAIL reset_busy_b got=%b exp=0", b_busy); end
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (a_busy && n < 100) begin tick(); n++; end
    total++; if (n !== 32) begin bad++; $display("FAIL reset_sweep_len got=%0d exp=32", n); end
    total++; if (b_busy !== 1'b0) begin bad++; $display("FAIL b_idle_after_reset got=%b exp=0", b_busy); end
    for (int i = 0; i < 32; i++) begin
      a_drive(1'b0, 1'b1, 5'(i), 8'h00);
      tick();
      total++; if (a_data_out !== 8'h00 || a_rd_valid !== 1'b1) begin
        bad++; $display("FAIL sweep_read[%0d] got=%h/%b exp=00/1", i, a_data_out, a_rd_valid);
      end
    end
    a_drive(1'b0, 1'b0, 5'd0, 8'h00);
    tick();
    total++; if (a_rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_drop got=%b exp=0", a_rd_valid); end
  endtask

  task automatic test_write_read();
    a_drive(1'b1, 1'b0, 5'd25, 8'h01);
    tick();
    total++; if (a_rd_valid !== 1'b0 || a_err !== 1'b0) begin bad++; $display("FAIL wr25_flags got=%b/%b exp=0/0", a_rd_valid, a_err); end
    a_drive(1'b0, 1'b1, 5'd25, 8'h00);
    tick();
    total++; if (a_data_out !== 8'h01 || a_rd_valid !== 1'b1) begin bad++; $display("FAIL rd25 got=%h/%b exp=01/1", a_data_out, a_rd_valid); end
    a_drive(1'b0, 1'b0, 5'd25, 8'h00);
    tick();
    total++; if (a_data_out !== 8'h01 || a_rd_valid !== 1'b0) begin bad++; $display("FAIL rd25_hold got=%h/%b exp=01/0", a_data_out, a_rd_valid); end
    tick();
    total++; if (a_data_out !== 8'h01) begin bad++; $display("FAIL rd25_hold2 got=%h exp=01", a_data_out); end
  endtask

  task automatic test_rdw_old();
    a_drive(1'b1, 1'b0, 5'd7, 8'h55);
    tick();
    a_drive(1'b1, 1'b1, 5'd7, 8'hAA);
    tick();
    total++; if (a_data_out !== 8'h55 || a_rd_valid !== 1'b1) begin bad++; $display("FAIL rdw_old got=%h/%b exp=55/1", a_data_out, a_rd_valid); end
    a_drive(1'b0, 1'b1, 5'd7, 8'h00);
    tick();
    total++; if (a_data_out !== 8'hAA) begin bad++; $display("FAIL rdw_old_after got=%h exp=aa", a_data_out); end
    a_drive(1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic test_busy_access();
    int n;
    a_drive(1'b0, 1'b0, 5'd0, 8'h00);
    a_clear_req = 1'b1;
    tick();
    a_clear_req = 1'b0;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL clear_req_busy got=%b exp=1", a_busy); end
    n = 0;
    repeat (10) begin tick(); n++; end
    // cnt is past 3 here, so a leaked write would survive the sweep
    a_drive(1'b1, 1'b0, 5'd3, 8'h33);
    tick(); n++;
    total++; if (a_err !== 1'b1 || a_rd_valid !== 1'b0) begin bad++; $display("FAIL busy_write got=%b/%b exp=1/0", a_err, a_rd_valid); end
    a_drive(1'b0, 1'b1, 5'd7, 8'h00);
    tick(); n++;
    total++; if (a_err !== 1'b1 || a_rd_valid !== 1'b0 || a_data_out !== 8'hAA) begin
      bad++; $display("FAIL busy_read got=%b/%b/%h exp=1/0/aa", a_err, a_rd_valid, a_data_out);
    end
    a_drive(1'b0, 1'b0, 5'd0, 8'h00);
    tick(); n++;
    total++; if (a_err !== 1'b0) begin bad++; $display("FAIL busy_err_drop got=%b exp=0", a_err); end
    while (a_busy && n < 100) begin tick(); n++; end
    total++; if (n !== 32) begin bad++; $display("FAIL clear_req_sweep_len got=%0d exp=32", n); end
    a_drive(1'b0, 1'b1, 5'd3, 8'h00);
    tick();
    total++; if (a_data_out !== 8'h00 || a_rd_valid !== 1'b1) begin bad++; $display("FAIL rd3_after_sweep got=%h/%b exp=00/1", a_data_out, a_rd_valid); end
    a_drive(1'b0, 1'b1, 5'd25, 8'h00);
    tick();
    total++; if (a_data_out !== 8'h00) begin bad++; $display("FAIL rd25_after_sweep got=%h exp=00", a_data_out); end
    a_drive(1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    a_drive(1'b1, 1'b0, 5'd20, 8'h5A);
    tick();
    a_drive(1'b0, 1'b1, 5'd20, 8'h00);
    tick();
    total++; if (a_data_out !== 8'h5A) begin bad++; $display("FAIL rd20_pre got=%h exp=5a", a_data_out); end
    a_drive(1'b0, 1'b0, 5'd0, 8'h00);
    a_clear_req = 1'b1;
    tick();
    a_clear_req = 1'b0;
    repeat (9) tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (a_busy !== 1'b1 || a_data_out !== 8'h00 || a_rd_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset got=%b/%h/%b exp=1/00/0", a_busy, a_data_out, a_rd_valid);
    end
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (a_busy && n < 100) begin
      tick(); n++;
      if (a_busy) begin
        @(negedge clk);
        a_clear_req = (n == 5);
      end
    end
    a_clear_req = 1'b0;
    total++; if (n !== 32) begin bad++; $display("FAIL restart_sweep_len got=%0d exp=32", n); end
    a_drive(1'b0, 1'b1, 5'd20, 8'h00);
    tick();
    total++; if (a_data_out !== 8'h00 || a_rd_valid !== 1'b1) begin bad++; $display("FAIL rd20_post got=%h/%b exp=00/1", a_data_out, a_rd_valid); end
    a_drive(1'b0, 1'b0, 5'd0, 8'h00);
  endtask

  task automatic test_b_clear();
    int n;
    b_drive(1'b0, 1'b0, 5'd0, 8'h00);
    b_clear_req = 1'b1;
    tick();
    b_clear_req = 1'b0;
    total++; if (b_busy !== 1'b1) begin bad++; $display("FAIL b_clear_busy got=%b exp=1", b_busy); end
    n = 0;
    while (b_busy && n < 100) begin tick(); n++; end
    total++; if (n !== 24) begin bad++; $display("FAIL b_sweep_len got=%0d exp=24", n); end
    b_drive(1'b0, 1'b1, 5'd23, 8'h00);
    tick();
    total++; if (b_data_out !== 8'hA5 || b_rd_valid !== 1'b1 || b_err !== 1'b0) begin
      bad++; $display("FAIL b_rd23 got=%h/%b/%b exp=a5/1/0", b_data_out, b_rd_valid, b_err);
    end
    b_drive(1'b0, 1'b1, 5'd0, 8'h00);
    tick();
    total++; if (b_data_out !== 8'hA5) begin bad++; $display("FAIL b_rd0 got=%h exp=a5", b_data_out); end
  endtask

  task automatic test_b_rdw_and_depth();
    b_drive(1'b1, 1'b1, 5'd7, 8'hAA);
    tick();
    total++; if (b_data_out !== 8'hAA || b_rd_valid !== 1'b1) begin bad++; $display("FAIL b_rdw_new got=%h/%b exp=aa/1", b_data_out, b_rd_valid); end
    b_drive(1'b1, 1'b0, 5'd30, 8'h77);
    tick();
    total++; if (b_err !== 1'b1 || b_rd_valid !== 1'b0 || b_data_out !== 8'hAA) begin
      bad++; $display("FAIL b_wr30 got=%b/%b/%h exp=1/0/aa", b_err, b_rd_valid, b_data_out);
    end
    b_drive(1'b0, 1'b1, 5'd30, 8'h00);
    tick();
    total++; if (b_data_out !== 8'h00 || b_rd_valid !== 1'b1 || b_err !== 1'b1) begin
      bad++; $display("FAIL b_rd30 got=%h/%b/%b exp=00/1/1", b_data_out, b_rd_valid, b_err);
    end
    b_drive(1'b1, 1'b0, 5'd23, 8'h11);
    tick();
    total++; if (b_err !== 1'b0) begin bad++; $display("FAIL b_wr23_err got=%b exp=0", b_err); end
    b_drive(1'b0, 1'b1, 5'd23, 8'h00);
    tick();
    total++; if (b_data_out !== 8'h11) begin bad++; $display("FAIL b_rd23_new got=%h exp=11", b_data_out); end
    b_drive(1'b0, 1'b1, 5'd7, 8'h00);
    tick();
    total++; if (b_data_out !== 8'hAA) begin bad++; $display("FAIL b_rd7 got=%h exp=aa", b_data_out); end
    b_drive(1'b0, 1'b0, 5'd0, 8'h00);
    tick();
    total++; if (b_data_out !== 8'hAA || b_rd_valid !== 1'b0 || b_err !== 1'b0) begin
      bad++; $display("FAIL b_quiet got=%h/%b/%b exp=aa/0/0", b_data_out, b_rd_valid, b_err);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_rdw_old();
    test_busy_access();
    test_reset_mid_sweep();
    test_b_clear();
    test_b_rdw_and_depth();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
